wb4_dec: RTL and testbench



---
 rtl/wb4_dec_pkg.sv | 19 +
 rtl/wb4_dec_pend.sv | 31 +++
 rtl/wb4_dec.sv | 146 ++++++++++++++
 tb/tb_wb4_dec.sv | 366 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb4_dec_pkg.sv
// Shared types and width helpers for the wb4_dec pipelined Wishbone B4 address decoder.
package wb4_dec_pkg;

    typedef enum logic {
        DEC_IDLE,
        DEC_BUSY
    } dec_state_e;

    // Word-address width derived from the data width (byte lanes folded out).
    function automatic int addr_bits(input int arch);
        return arch - $clog2(arch / 8);
    endfunction

    // Width of a target index that also encodes the unmapped target (== slave count).
    function automatic int tgt_bits(input int slaves);
        return (slaves < 1) ? 1 : $clog2(slaves + 1);
    endfunction

endpackage

// File: rtl/wb4_dec_pend.sv
// Saturating outstanding-request counter for wb4_dec with empty/full flags.
module wb4_dec_pend #(
    parameter int PENDMAX = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    input  logic dec,
    output logic empty,
    output logic full
);

    localparam int CW = $clog2(PENDMAX + 1);

    logic [CW-1:0] cnt;

    assign empty = (cnt == '0);
    assign full  = (cnt == CW'(PENDMAX));

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (inc && !dec && !full) begin
            cnt <= cnt + 1'b1;
        end else if (dec && !inc && !empty) begin
            cnt <= cnt - 1'b1;
        end
    end

endmodule

// File: rtl/wb4_dec.sv
// Wishbone B4 pipelined address decoder: one master to SLAVECOUNT slaves, in-order responses.
// Optional macro WB4DEC_ERR_EN adds m_wb_err_o, used instead of ack for unmapped accesses.
module wb4_dec
    import wb4_dec_pkg::*;
#(
    parameter int ARCHBITSZ  = 16,
    parameter int SLAVECOUNT = 2,
    parameter int PENDMAX    = 4,
    parameter logic [SLAVECOUNT*addr_bits(ARCHBITSZ)-1:0] SLAVEBASE = '0,
    parameter logic [SLAVECOUNT*addr_bits(ARCHBITSZ)-1:0] SLAVEMASK = '0,
    localparam int ADDRBITSZ = addr_bits(ARCHBITSZ),
    localparam int SELBITSZ  = ARCHBITSZ / 8
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic                            m_wb_cyc_i,
    input  logic                            m_wb_stb_i,
    input  logic                            m_wb_we_i,
    input  logic [ADDRBITSZ-1:0]            m_wb_addr_i,
    input  logic [SELBITSZ-1:0]             m_wb_sel_i,
    input  logic [ARCHBITSZ-1:0]            m_wb_dat_i,
    output logic                            m_wb_bsy_o,
    output logic                            m_wb_ack_o,
    output logic [ARCHBITSZ-1:0]            m_wb_dat_o,
`ifdef WB4DEC_ERR_EN
    output logic                            m_wb_err_o,
`endif
    output logic [SLAVECOUNT-1:0]           s_wb_cyc_o,
    output logic [SLAVECOUNT-1:0]           s_wb_stb_o,
    output logic                            s_wb_we_o,
    output logic [ADDRBITSZ-1:0]            s_wb_addr_o,
    output logic [SELBITSZ-1:0]             s_wb_sel_o,
    output logic [ARCHBITSZ-1:0]            s_wb_dat_o,
    input  logic [SLAVECOUNT-1:0]           s_wb_bsy_i,
    input  logic [SLAVECOUNT-1:0]           s_wb_ack_i,
    input  logic [SLAVECOUNT*ARCHBITSZ-1:0] s_wb_dat_i
);

    localparam int TW = tgt_bits(SLAVECOUNT);
    localparam logic [TW-1:0] UNMAPPED = TW'(SLAVECOUNT);

    logic [TW-1:0]        dec_tgt;
    logic [TW-1:0]        tgt_q;
    logic                 uack_q;
    logic                 pend_empty;
    logic                 pend_full;
    logic                 busy;
    logic                 acc;
    logic                 hit_any;
    logic                 sel_bsy;
    logic                 tgt_ack;
    logic [ARCHBITSZ-1:0] tgt_dat;
    logic                 slave_rsp;
    logic                 unmap_rsp;
    logic                 rsp;
    dec_state_e           state;

    // Lowest matching slave wins; no match selects the internal unmapped target.
    always_comb begin
        dec_tgt = UNMAPPED;
        hit_any = 1'b0;
        for (int unsigned i = 0; i < SLAVECOUNT; i++) begin
            if (!hit_any &&
                ((m_wb_addr_i & SLAVEMASK[i*ADDRBITSZ +: ADDRBITSZ]) ==
                 SLAVEBASE[i*ADDRBITSZ +: ADDRBITSZ])) begin
                dec_tgt = TW'(i);
                hit_any = 1'b1;
            end
        end
    end

    always_comb begin
        sel_bsy = 1'b0;
        tgt_ack = 1'b0;
        tgt_dat = '0;
        for (int unsigned i = 0; i < SLAVECOUNT; i++) begin
            if (dec_tgt == TW'(i)) begin
                sel_bsy = s_wb_bsy_i[i];
            end
            if (tgt_q == TW'(i)) begin
                tgt_ack = s_wb_ack_i[i];
                tgt_dat = s_wb_dat_i[i*ARCHBITSZ +: ARCHBITSZ];
            end
        end
    end

    assign state = pend_empty ? DEC_IDLE : DEC_BUSY;
    assign busy  = (state == DEC_BUSY);

    // A change of target must wait for every outstanding response to drain.
    assign m_wb_bsy_o = pend_full || (busy && (dec_tgt != tgt_q)) || sel_bsy;
    assign acc        = m_wb_cyc_i && m_wb_stb_i && !m_wb_bsy_o;

    always_comb begin
        s_wb_stb_o = '0;
        s_wb_cyc_o = '0;
        for (int unsigned i = 0; i < SLAVECOUNT; i++) begin
            s_wb_stb_o[i] = m_wb_cyc_i && m_wb_stb_i && (dec_tgt == TW'(i)) &&
                            !pend_full && (!busy || (tgt_q == TW'(i)));
            s_wb_cyc_o[i] = m_wb_cyc_i && (s_wb_stb_o[i] || (busy && (tgt_q == TW'(i))));
        end
    end

    assign s_wb_we_o   = m_wb_we_i;
    assign s_wb_addr_o = m_wb_addr_i;
    assign s_wb_sel_o  = m_wb_sel_i;
    assign s_wb_dat_o  = m_wb_dat_i;

    assign slave_rsp = m_wb_cyc_i && busy && (tgt_q != UNMAPPED) && tgt_ack;
    assign unmap_rsp = m_wb_cyc_i && busy && (tgt_q == UNMAPPED) && uack_q;
    assign rsp       = slave_rsp || unmap_rsp;

`ifdef WB4DEC_ERR_EN
    assign m_wb_ack_o = slave_rsp;
    assign m_wb_err_o = unmap_rsp;
`else
    assign m_wb_ack_o = rsp;
`endif
    assign m_wb_dat_o = slave_rsp ? tgt_dat : '0;

    // uack_q is a one-cycle echo of an accepted unmapped request; dropping cyc clears it via acc.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tgt_q  <= '0;
            uack_q <= 1'b0;
        end else begin
            if (acc) begin
                tgt_q <= dec_tgt;
            end
            uack_q <= acc && (dec_tgt == UNMAPPED);
        end
    end

    wb4_dec_pend #(
        .PENDMAX(PENDMAX)
    ) u_pend (
        .clk  (clk_i),
        .rst  (rst_i),
        .clr  (!m_wb_cyc_i),
        .inc  (acc),
        .dec  (rsp),
        .empty(pend_empty),
        .full (pend_full)
    );

endmodule

// File: tb/tb_wb4_dec.sv
// Directed self-checking bench for wb4_dec: transaction-queue model checked every cycle plus literal checks.
`timescale 1ns/1ps
module tb_wb4_dec;

    localparam int ARCH = 32;
    localparam int AW   = 30;
    localparam int SC   = 2;
    localparam int PM   = 4;
    // Two-bit masks so that 0x8000 falls outside both slave windows.
    localparam logic [SC*AW-1:0] BASE = {30'h0000_4000, 30'h0000_0000};
    localparam logic [SC*AW-1:0] MASK = {30'h0000_C000, 30'h0000_C000};

    logic              clk = 1'b0;
    logic              rst;
    logic              m_cyc, m_stb, m_we;
    logic [AW-1:0]     m_addr;
    logic [3:0]        m_sel;
    logic [ARCH-1:0]   m_wdat;
    logic              m_bsy, m_ack;
    logic [ARCH-1:0]   m_rdat;
`ifdef WB4DEC_ERR_EN
    logic              m_err;
`endif
    logic [SC-1:0]     s_cyc, s_stb;
    logic              s_we;
    logic [AW-1:0]     s_addr;
    logic [3:0]        s_sel;
    logic [ARCH-1:0]   s_wdat;
    logic [SC-1:0]     s_bsy, s_ack;
    logic [SC*ARCH-1:0] s_rdat;

    wb4_dec #(
        .ARCHBITSZ (ARCH),
        .SLAVECOUNT(SC),
        .PENDMAX   (PM),
        .SLAVEBASE (BASE),
        .SLAVEMASK (MASK)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .m_wb_cyc_i (m_cyc),
        .m_wb_stb_i (m_stb),
        .m_wb_we_i  (m_we),
        .m_wb_addr_i(m_addr),
        .m_wb_sel_i (m_sel),
        .m_wb_dat_i (m_wdat),
        .m_wb_bsy_o (m_bsy),
        .m_wb_ack_o (m_ack),
        .m_wb_dat_o (m_rdat),
`ifdef WB4DEC_ERR_EN
        .m_wb_err_o (m_err),
`endif
        .s_wb_cyc_o (s_cyc),
        .s_wb_stb_o (s_stb),
        .s_wb_we_o  (s_we),
        .s_wb_addr_o(s_addr),
        .s_wb_sel_o (s_sel),
        .s_wb_dat_o (s_wdat),
        .s_wb_bsy_i (s_bsy),
        .s_wb_ack_i (s_ack),
        .s_wb_dat_i (s_rdat)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        int          due;
        logic [31:0] d;
    } rsp_t;

    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc_n   = 0;
    int   dly0 = 1, dly1 = 1;
    rsp_t sq0[$];
    rsp_t sq1[$];
    int   outq[$];
    bit   uack_m;
    bit   chk_en = 0;
    bit   m_acc;
    int   acc_cyc_m;
    int   obs_ack, obs_err, obs_first, obs_stb0, obs_stb1;
    logic [31:0] obs_dat, obs_firstdat;

    always @(posedge clk) cyc_n <= cyc_n + 1;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc_n, got, exp);
        end
    endtask

    function automatic int decode(input logic [AW-1:0] a);
        int base_a [SC] = '{32'h0000, 32'h4000};
        int mask_a [SC] = '{32'hC000, 32'hC000};
        for (int i = 0; i < SC; i++)
            if ((int'(a) & mask_a[i]) == base_a[i]) return i;
        return SC;
    endfunction

    function automatic logic [31:0] slave_data(input int s, input logic [AW-1:0] a);
        return (s == 0) ? ({2'b00, a} ^ 32'h5A5A_0000) : ({2'b00, a} ^ 32'h0000_FEFF);
    endfunction

    // Model: queue of outstanding targets; the head's target is the locked one.
    int            d, lock;
    bit            busy_m, full_m, sl_rsp, un_rsp, e_bsy, e_ack, e_err;
    logic [SC-1:0] e_stb, e_cyc;
    logic [31:0]   e_dat;

    always @(negedge clk) begin
        d      = decode(m_addr);
        busy_m = outq.size() > 0;
        lock   = busy_m ? outq[0] : -1;
        full_m = outq.size() >= PM;
        e_bsy  = full_m || (busy_m && d != lock) || (d < SC && s_bsy[d]);
        for (int i = 0; i < SC; i++) begin
            e_stb[i] = m_cyc && m_stb && d == i && !full_m && (!busy_m || lock == i);
            e_cyc[i] = m_cyc && (e_stb[i] || (busy_m && lock == i));
        end
        sl_rsp = 0;
        if (busy_m && lock < SC) sl_rsp = m_cyc && s_ack[lock];
        un_rsp = m_cyc && busy_m && lock == SC && uack_m;
`ifdef WB4DEC_ERR_EN
        e_ack = sl_rsp;
        e_err = un_rsp;
`else
        e_ack = sl_rsp || un_rsp;
        e_err = 0;
`endif
        e_dat = sl_rsp ? s_rdat[lock*32 +: 32] : 32'h0;
        m_acc = m_cyc && m_stb && !e_bsy && !rst;

        if (chk_en) begin
            check("bsy", {63'd0, m_bsy}, {63'd0, e_bsy});
            check("ack", {63'd0, m_ack}, {63'd0, e_ack});
`ifdef WB4DEC_ERR_EN
            check("err", {63'd0, m_err}, {63'd0, e_err});
`endif
            check("rdat", {32'd0, m_rdat}, {32'd0, e_dat});
            check("s_stb", {62'd0, s_stb}, {62'd0, e_stb});
            check("s_cyc", {62'd0, s_cyc}, {62'd0, e_cyc});
            check("passthru", {s_we, s_addr, s_sel, s_wdat[28:0]},
                  {m_we, m_addr, m_sel, m_wdat[28:0]});
        end

        if (m_ack) begin
            obs_ack++;
            obs_dat = m_rdat;
            if (obs_first < 0) begin
                obs_first    = cyc_n;
                obs_firstdat = m_rdat;
            end
        end
`ifdef WB4DEC_ERR_EN
        if (m_err) begin
            obs_err++;
            if (obs_first < 0) obs_first = cyc_n;
        end
`endif
        obs_stb0 += int'(s_stb[0]);
        obs_stb1 += int'(s_stb[1]);
        if (m_acc) acc_cyc_m = cyc_n;

        if (rst) begin
            outq.delete();
            uack_m = 0;
            sq0.delete();
            sq1.delete();
        end else begin
            if (e_stb[0] && !s_bsy[0]) sq0.push_back('{due: cyc_n + dly0, d: slave_data(0, m_addr)});
            if (e_stb[1] && !s_bsy[1]) sq1.push_back('{due: cyc_n + dly1, d: slave_data(1, m_addr)});
            if (!m_cyc) begin
                outq.delete();
                uack_m = 0;
            end else begin
                if (sl_rsp || un_rsp) void'(outq.pop_front());
                if (m_acc) outq.push_back(d);
                uack_m = m_acc && d == SC;
            end
        end
    end

    // Slave responders: one in-order ack per cycle, garbage data when idle.
    initial begin
        s_ack  = '0;
        s_bsy  = '0;
        s_rdat = {32'hCAFE_0001, 32'hCAFE_0000};
        forever begin
            @(posedge clk);
            #1;
            s_ack  = '0;
            s_rdat = {32'hCAFE_0001, 32'hCAFE_0000};
            if (sq0.size() > 0 && sq0[0].due <= cyc_n) begin
                s_ack[0]     = 1'b1;
                s_rdat[31:0] = sq0[0].d;
                void'(sq0.pop_front());
            end
            if (sq1.size() > 0 && sq1[0].due <= cyc_n) begin
                s_ack[1]      = 1'b1;
                s_rdat[63:32] = sq1[0].d;
                void'(sq1.pop_front());
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_obs();
        obs_ack   = 0;
        obs_err   = 0;
        obs_first = -1;
        obs_stb0  = 0;
        obs_stb1  = 0;
        obs_dat   = 32'h0;
    endtask

    task automatic issue(input logic [AW-1:0] a, input logic we, output int stalls, output int acyc);
        bit done = 0;
        m_cyc  = 1'b1;
        m_stb  = 1'b1;
        m_we   = we;
        m_addr = a;
        m_sel  = we ? 4'hF : 4'h3;
        m_wdat = 32'h1234_0000 | {2'b00, a};
        stalls = 0;
        for (int k = 0; k < 40 && !done; k++) begin
            @(posedge clk);
            if (m_acc) done = 1;
            else stalls++;
        end
        #1;
        m_stb = 1'b0;
        acyc  = acc_cyc_m;
        if (!done) check("accept_timeout", 64'd0, 64'd1);
    endtask

    task automatic wait_resp(input int n);
        int k = 0;
        while ((obs_ack + obs_err) < n && k < 60) begin
            step();
            k++;
        end
        if ((obs_ack + obs_err) < n) check("resp_timeout", 64'(obs_ack + obs_err), 64'(n));
    endtask

    int st, ac, st5, ac5, sum_st;

    initial begin
        rst = 1'b1; m_cyc = 0; m_stb = 0; m_we = 0;
        m_addr = '0; m_sel = '0; m_wdat = '0;
        clear_obs();
        step();
        chk_en = 1;
        step();
        check("reset_ack", {63'd0, m_ack}, 64'd0);
        check("reset_rdat", {32'd0, m_rdat}, 64'd0);
        check("reset_s_cyc_stb", {60'd0, s_cyc, s_stb}, 64'd0);
        check("reset_bsy", {63'd0, m_bsy}, 64'd0);
        rst = 1'b0;
        step();

        // Single read to slave 1, ack two cycles after accept.
        clear_obs();
        dly1 = 2;
        issue(30'h4010, 1'b0, st, ac);
        wait_resp(1);
        step();
        check("t1_stalls", 64'(st), 64'd0);
        check("t1_acks", 64'(obs_ack), 64'd1);
        check("t1_data", {32'd0, obs_dat}, 64'h0000_BEEF);
        check("t1_stb_pulses", {32'(obs_stb0), 32'(obs_stb1)}, {32'd0, 32'd1});
        check("t1_drained_s_cyc", {62'd0, s_cyc}, 64'd0);

        // Five back-to-back reads to slave 0 with ack latency 6.
        clear_obs();
        dly0 = 6;
        sum_st = 0;
        for (int i = 0; i < 4; i++) begin
            issue(AW'(32'h10 + i), 1'b0, st, ac);
            sum_st += st;
        end
        issue(30'h14, 1'b0, st5, ac5);
        wait_resp(5);
        step();
        check("t2_first4_stalls", 64'(sum_st), 64'd0);
        check("t2_fifth_stalls", 64'(st5), 64'd3);
        check("t2_accept_after_ack", 64'(ac5 - obs_first), 64'd1);
        check("t2_acks", 64'(obs_ack), 64'd5);

        // Target switch waits for slave 0 to drain.
        clear_obs();
        dly0 = 3;
        dly1 = 1;
        issue(30'h20, 1'b0, st, ac);
        issue(30'h4020, 1'b0, st, ac);
        wait_resp(2);
        step();
        check("t3_switch_stalls", 64'(st), 64'd3);
        check("t3_first_data", {32'd0, obs_firstdat}, 64'h5A5A_0020);
        check("t3_second_data", {32'd0, obs_dat}, 64'h0000_BEDF);

        // Unmapped read then write.
        clear_obs();
        issue(30'h8000, 1'b0, st, ac);
        issue(30'h8004, 1'b1, st, ac5);
        step();
        step();
        check("t4_latency", 64'(obs_first - ac), 64'd1);
        check("t4_no_slave_stb", {32'(obs_stb0), 32'(obs_stb1)}, 64'd0);
`ifdef WB4DEC_ERR_EN
        check("t4_err_count", {32'(obs_ack), 32'(obs_err)}, {32'd0, 32'd2});
`else
        check("t4_ack_count", {32'(obs_ack), 32'(obs_err)}, {32'd2, 32'd0});
        check("t4_data", {32'd0, obs_dat}, 64'd0);
`endif

        // Master abort with two pending, acks arrive after cyc returns.
        dly0 = 3;
        issue(30'h30, 1'b0, st, ac);
        issue(30'h31, 1'b0, st, ac);
        clear_obs();
        m_cyc = 1'b0;
        step();
        m_cyc = 1'b1;
        check("t5_s_cyc_after_abort", {62'd0, s_cyc}, 64'd0);
        step();
        step();
        step();
        check("t5_no_acks", 64'(obs_ack), 64'd0);
        check("t5_s_cyc_idle", {62'd0, s_cyc}, 64'd0);

        // Reset with three pending, then a normal read.
        dly0 = 8;
        for (int i = 0; i < 3; i++) issue(AW'(32'h40 + i), 1'b0, st, ac);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("t6_reset_ack_dat", {31'd0, m_ack, m_rdat}, 64'd0);
        check("t6_reset_s_cyc_stb", {60'd0, s_cyc, s_stb}, 64'd0);
        clear_obs();
        dly1 = 2;
        issue(30'h4010, 1'b0, st, ac);
        wait_resp(1);
        step();
        check("t6_post_reset_read", {32'(obs_ack), obs_dat}, {32'd1, 32'h0000_BEEF});

        m_cyc = 1'b0;
        step();
        step();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
